// File: rtl/pwm_ramp_sequencer_if.sv
// ---------------------------------------------------------------------------
// pwm_ramp_sequencer_if
//   Request/response bundle between the host (start/stop/target requests) and
//   the soft-start/soft-stop duty sequencer.
//
//   Host -> sequencer : start_i, stop_i, target_i[2:0], dwell_i[DwellWidth-1:0]
//   Sequencer -> host : opc_o[2:0], period_tick_o, busy_o, done_o
//
//   modport master : the requesting side (host / test logic)
//   modport slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface pwm_ramp_sequencer_if #(
  parameter int DwellWidth = 8
);
  logic                  start_i;
  logic                  stop_i;
  logic [2:0]            target_i;
  logic [DwellWidth-1:0] dwell_i;
  logic [2:0]            opc_o;
  logic                  period_tick_o;
  logic                  busy_o;
  logic                  done_o;

  modport master (
    output start_i, stop_i, target_i, dwell_i,
    input  opc_o, period_tick_o, busy_o, done_o
  );

  modport slave (
    input  start_i, stop_i, target_i, dwell_i,
    output opc_o, period_tick_o, busy_o, done_o
  );
endinterface : pwm_ramp_sequencer_if

// File: rtl/pwm_ramp_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_ramp_sequencer
//   Soft-start / soft-stop controller for the 8-bit PWM counter. Produces the
//   3-bit duty code (opc) and walks it one step at a time toward a requested
//   goal, changing it only at PWM period boundaries so the load never sees an
//   abrupt duty jump.
//
// Parameters
//   PeriodLen  : clocks per PWM period (>= 2), matches the counter's sweep
//   DwellWidth : width of the periods-per-step field
//
// Ports
//   clk_i  : clock
//   rst_i  : asynchronous, active-high reset
//   bus    : slave side of pwm_ramp_sequencer_if
//            start_i/stop_i   one-cycle requests
//            target_i         requested duty code (7 is clamped to 6)
//            dwell_i          periods per step (0 behaves as 1)
//            opc_o            registered duty code to the PWM counter
//            period_tick_o    high on the last clock of each PWM period
//            busy_o           high while ramping
//            done_o           registered one-cycle completion pulse
// ---------------------------------------------------------------------------
module pwm_ramp_sequencer #(
  parameter int PeriodLen  = 101,
  parameter int DwellWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pwm_ramp_sequencer_if.slave  bus
);

  localparam int                PcntW     = $clog2(PeriodLen);
  localparam logic [PcntW-1:0]  PcntLast  = PcntW'(PeriodLen - 1);
  localparam logic [2:0]        CodeFull  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e                state_q;
  logic [PcntW-1:0]      pcnt_q;
  logic [PcntW-1:0]      pcnt_d;
  logic [2:0]            goal_q;
  logic [2:0]            opc_q;
  logic [DwellWidth-1:0] dwell_q;
  logic [DwellWidth-1:0] dw_cnt_q;
  logic                  stopping_q;
  logic                  done_q;

  logic                  tick;
  logic [2:0]            tgt_clamp;
  logic [DwellWidth-1:0] dwell_eff;
  logic                  step_due;
  logic [2:0]            opc_step;
  logic                  start_ok;
  logic                  stop_ok;

  // Combinational helpers: tick decode, request clamping, next step value.
  always_comb begin
    tick      = (pcnt_q == PcntLast);
    pcnt_d    = tick ? '0 : pcnt_q + PcntW'(1);
    tgt_clamp = (bus.target_i == 3'd7) ? CodeFull : bus.target_i;
    dwell_eff = (bus.dwell_i == '0) ? DwellWidth'(1) : bus.dwell_i;
    step_due  = (dw_cnt_q == dwell_q - DwellWidth'(1));
    // Unsigned compare decides direction, so a lower retarget ramps down.
    opc_step  = (goal_q > opc_q) ? opc_q + 3'd1 : opc_q - 3'd1;
    stop_ok   = bus.stop_i && (state_q != IDLE);
    start_ok  = bus.start_i && (state_q != STEP);
  end

  // Free-running period counter; shares reset with the PWM counter so the
  // tick lines up with the counter's wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  // Sequencer FSM with registered opc/done.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      goal_q     <= 3'd0;
      opc_q      <= 3'd0;
      dwell_q    <= DwellWidth'(1);
      dw_cnt_q   <= '0;
      stopping_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop_ok) begin
        // Stop wins over a simultaneous start.
        goal_q   <= 3'd0;
        dwell_q  <= dwell_eff;
        dw_cnt_q <= '0;
        if (opc_q == 3'd0) begin
          done_q     <= 1'b1;
          stopping_q <= 1'b0;
          state_q    <= IDLE;
        end else begin
          stopping_q <= 1'b1;
          state_q    <= STEP;
        end
      end else if (start_ok) begin
        goal_q     <= tgt_clamp;
        dwell_q    <= dwell_eff;
        dw_cnt_q   <= '0;
        stopping_q <= 1'b0;
        if (tgt_clamp != opc_q) begin
          state_q <= STEP;
        end else begin
          done_q <= 1'b1;
          // A zero goal from IDLE has nothing to hold.
          if ((state_q == IDLE) && (tgt_clamp == 3'd0)) begin
            state_q <= IDLE;
          end else begin
            state_q <= HOLD;
          end
        end
      end else if ((state_q == STEP) && tick) begin
        if (step_due) begin
          dw_cnt_q <= '0;
          opc_q    <= opc_step;
          // done rises on the same edge the final code is loaded.
          if (opc_step == goal_q) begin
            done_q     <= 1'b1;
            stopping_q <= 1'b0;
            state_q    <= stopping_q ? IDLE : HOLD;
          end
        end else begin
          dw_cnt_q <= dw_cnt_q + DwellWidth'(1);
        end
      end
    end
  end

  assign bus.opc_o         = opc_q;
  assign bus.period_tick_o = tick;
  assign bus.busy_o        = (state_q == STEP);
  assign bus.done_o        = done_q;

endmodule : pwm_ramp_sequencer

// File: tb/tb_pwm_ramp_sequencer.sv
module tb_pwm_ramp_sequencer;

  localparam int PL = 11;
  localparam int DW = 8;
  localparam int DRAIN_BUDGET = 1500;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  pwm_ramp_sequencer_if #(.DwellWidth(DW)) bus ();

  pwm_ramp_sequencer #(.PeriodLen(PL), .DwellWidth(DW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Expected output events: {opc, done, busy, ticks-since-acceptance}.
  logic [31:0] sb[$];
  int          tick_cnt = 0;
  logic [2:0]  prev_opc = 3'd0;
  bit          mon_en   = 1'b0;
  int          bpcnt    = 0;
  logic [31:0] ev_got;
  logic [31:0] ev_exp;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ev(input logic [2:0] o, input logic d, input logic b, input int t);
    logic [7:0] t8;
    t8 = t[7:0];
    return {19'd0, o, d, b, t8};
  endfunction

  // Independent reference for the period counter position.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) bpcnt <= 0;
    else       bpcnt <= (bpcnt == PL - 1) ? 0 : bpcnt + 1;
  end

  // Output monitor: every code change or done pulse is an event popped from
  // the scoreboard.
  always @(negedge clk_i) begin
    if (mon_en) begin
      chk_val("period_tick", {31'd0, bus.period_tick_o}, {31'd0, (bpcnt == PL - 1)});
      if ((bus.opc_o != prev_opc) || bus.done_o) begin
        ev_got = ev(bus.opc_o, bus.done_o, bus.busy_o, tick_cnt);
        if (sb.size() == 0) begin
          chk_val("unexpected_event", ev_got, 32'hFFFF_FFFF);
        end else begin
          ev_exp = sb.pop_front();
          chk_val("event", ev_got, ev_exp);
        end
      end
      prev_opc = bus.opc_o;
      if (bus.period_tick_o) tick_cnt++;
    end
  end

  task automatic req(input logic s, input logic p, input logic [2:0] tgt,
                     input logic [DW-1:0] dw, input bit accepted);
    @(posedge clk_i); #1;
    bus.start_i  = s;
    bus.stop_i   = p;
    bus.target_i = tgt;
    bus.dwell_i  = dw;
    @(posedge clk_i); #1;
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
    if (accepted) tick_cnt = 0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DRAIN_BUDGET; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk_i);
    end
    chk_val(tag, sb.size(), 0);
    sb.delete();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk_i);
    #1;
  endtask

  initial begin
    bus.start_i  = 1'b0;
    bus.stop_i   = 1'b0;
    bus.target_i = 3'd0;
    bus.dwell_i  = '0;

    // Reset state.
    #3;
    chk_val("rst_opc",  {29'd0, bus.opc_o}, 0);
    chk_val("rst_busy", {31'd0, bus.busy_o}, 0);
    chk_val("rst_done", {31'd0, bus.done_o}, 0);
    chk_val("rst_tick", {31'd0, bus.period_tick_o}, 0);
    @(posedge clk_i); #2;
    rst_i  = 1'b0;
    mon_en = 1'b1;

    // Zero-length start from IDLE: done next cycle, never busy.
    sb.push_back(ev(3'd0, 1'b1, 1'b0, 0));
    req(1'b1, 1'b0, 3'd0, 8'd0, 1'b1);
    chk_val("zero_start_busy", {31'd0, bus.busy_o}, 0);
    drain("zero_start_drain");
    // Stop in IDLE: no response at all.
    req(1'b0, 1'b1, 3'd0, 8'd1, 1'b0);
    idle_cycles(2 * PL);
    chk_val("idle_stop_busy", {31'd0, bus.busy_o}, 0);

    // Reset mid-ramp at opc=2.
    sb.push_back(ev(3'd1, 1'b0, 1'b1, 1));
    sb.push_back(ev(3'd2, 1'b0, 1'b1, 2));
    req(1'b1, 1'b0, 3'd5, 8'd1, 1'b1);
    drain("pre_reset_drain");
    chk_val("pre_reset_busy", {31'd0, bus.busy_o}, 1);
    @(posedge clk_i); #3;
    mon_en = 1'b0;
    rst_i  = 1'b1;
    #1;
    chk_val("midrst_opc",  {29'd0, bus.opc_o}, 0);
    chk_val("midrst_busy", {31'd0, bus.busy_o}, 0);
    chk_val("midrst_done", {31'd0, bus.done_o}, 0);
    chk_val("midrst_tick", {31'd0, bus.period_tick_o}, 0);
    @(posedge clk_i); #2;
    rst_i    = 1'b0;
    prev_opc = 3'd0;
    tick_cnt = 0;
    mon_en   = 1'b1;
    idle_cycles(3 * PL);
    chk_val("post_rst_opc", {29'd0, bus.opc_o}, 0);

    // Ramp up to 3 with dwell 2: steps on ticks 2, 4, 6.
    sb.push_back(ev(3'd1, 1'b0, 1'b1, 2));
    sb.push_back(ev(3'd2, 1'b0, 1'b1, 4));
    sb.push_back(ev(3'd3, 1'b1, 1'b0, 6));
    req(1'b1, 1'b0, 3'd3, 8'd2, 1'b1);
    chk_val("ramp_busy_rise", {31'd0, bus.busy_o}, 1);
    drain("ramp_up_drain");

    // Stop from HOLD at 3 back to IDLE.
    sb.push_back(ev(3'd2, 1'b0, 1'b1, 1));
    sb.push_back(ev(3'd1, 1'b0, 1'b1, 2));
    sb.push_back(ev(3'd0, 1'b1, 1'b0, 3));
    req(1'b0, 1'b1, 3'd0, 8'd1, 1'b1);
    drain("hold_stop_drain");

    // Target 7 clamps to 6, dwell 0 behaves as 1.
    for (int k = 1; k <= 6; k++)
      sb.push_back(ev(3'(k), (k == 6), (k != 6), k));
    req(1'b1, 1'b0, 3'd7, 8'd0, 1'b1);
    drain("clamp_drain");
    idle_cycles(2 * PL);
    chk_val("clamp_hold_opc", {29'd0, bus.opc_o}, 6);

    // Retarget down from HOLD at 6 to 2.
    for (int k = 1; k <= 4; k++)
      sb.push_back(ev(3'(6 - k), (k == 4), (k != 4), k));
    req(1'b1, 1'b0, 3'd2, 8'd1, 1'b1);
    drain("retarget_drain");

    // Stop during a ramp at opc=2 with a simultaneous start, then a start
    // in STEP that must be ignored.
    req(1'b1, 1'b0, 3'd6, 8'd4, 1'b1);
    chk_val("slow_ramp_busy", {31'd0, bus.busy_o}, 1);
    sb.push_back(ev(3'd1, 1'b0, 1'b1, 1));
    sb.push_back(ev(3'd0, 1'b1, 1'b0, 2));
    req(1'b1, 1'b1, 3'd7, 8'd1, 1'b1);
    req(1'b1, 1'b0, 3'd6, 8'd1, 1'b0);
    drain("stop_ramp_drain");
    // Must now be IDLE (not HOLD at 0): a stop gets no done pulse.
    req(1'b0, 1'b1, 3'd0, 8'd1, 1'b0);
    idle_cycles(2 * PL);
    chk_val("final_opc",  {29'd0, bus.opc_o}, 0);
    chk_val("final_busy", {31'd0, bus.busy_o}, 0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pwm_ramp_sequencer
